// File: rtl/axil_usr_timeout_guard_if.sv
// AXI4-Lite channel bundle for the user-port timeout guard.
// The guard takes the slave modport upstream and the master modport downstream.
interface axil_usr_timeout_guard_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_usr_timeout_guard.sv
// AXI4-Lite guard that answers SLVERR upstream when the user DUT stalls, while still
// draining the late DUT transaction. Define AXIL_USR_TMO_ADDR_CAPTURE_EN to capture tmo_addr.
module axil_usr_timeout_guard #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      axi_aclk,
  input  logic                      axi_areset,
  axil_usr_timeout_guard_if.slave   s_axi,
  axil_usr_timeout_guard_if.master  m_axi,
  output logic                      wr_tmo_pulse,
  output logic                      rd_tmo_pulse,
  output logic [15:0]               tmo_count,
  output logic [ADDR_WIDTH-1:0]     tmo_addr
);
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_WIDTH-1:0] TmoLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {WrIdle, WrReq, WrResp, WrBresp, WrTmo} wr_state_e;
  typedef enum logic [2:0] {RdIdle, RdReq, RdResp, RdData, RdTmo} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic                    aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic                    aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, ar_pend_q, ar_pend_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [2:0]              awprot_q, awprot_d, arprot_q, arprot_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic                    wr_up_done_q, wr_up_done_d, wr_dn_done_q, wr_dn_done_d;
  logic                    rd_up_done_q, rd_up_done_d, rd_dn_done_q, rd_dn_done_d;
  logic [CNT_WIDTH-1:0]    wr_timer_q, wr_timer_d, rd_timer_q, rd_timer_d;
  logic                    wr_tmo, rd_tmo, wr_tmo_pulse_q, rd_tmo_pulse_q;
  logic [15:0]             tmo_count_q, tmo_count_d;
  logic [16:0]             tmo_sum;

  always_comb begin
    wr_state_d   = wr_state_q;
    aw_got_d     = aw_got_q;
    w_got_d      = w_got_q;
    awaddr_d     = awaddr_q;
    awprot_d     = awprot_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    bresp_d      = bresp_q;
    wr_up_done_d = wr_up_done_q;
    wr_dn_done_d = wr_dn_done_q;
    wr_timer_d   = wr_timer_q;
    wr_tmo       = 1'b0;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    if (aw_pend_q && m_axi.awready) aw_pend_d = 1'b0;
    if (w_pend_q && m_axi.wready)   w_pend_d  = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        s_axi.awready = !aw_got_q;
        s_axi.wready  = !w_got_q;
        if (s_axi.awvalid && !aw_got_q) begin
          aw_got_d = 1'b1;
          awaddr_d = s_axi.awaddr;
          awprot_d = s_axi.awprot;
        end
        if (s_axi.wvalid && !w_got_q) begin
          w_got_d = 1'b1;
          wdata_d = s_axi.wdata;
          wstrb_d = s_axi.wstrb;
        end
        if (aw_got_d && w_got_d) begin
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          aw_pend_d  = 1'b1;
          w_pend_d   = 1'b1;
          wr_timer_d = '0;
          wr_state_d = WrReq;
        end
      end
      WrReq: begin
        wr_timer_d = wr_timer_q + CNT_WIDTH'(1);
        if (wr_timer_q == TmoLast)        wr_tmo     = 1'b1;
        else if (!aw_pend_d && !w_pend_d) wr_state_d = WrResp;
      end
      WrResp: begin
        m_axi.bready = 1'b1;
        wr_timer_d   = wr_timer_q + CNT_WIDTH'(1);
        // A response landing on the last timer cycle beats the timeout.
        if (m_axi.bvalid) begin
          bresp_d    = m_axi.bresp;
          wr_state_d = WrBresp;
        end else if (wr_timer_q == TmoLast) begin
          wr_tmo = 1'b1;
        end
      end
      WrBresp: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) wr_state_d = WrIdle;
      end
      WrTmo: begin
        s_axi.bvalid = !wr_up_done_q;
        m_axi.bready = !aw_pend_q && !w_pend_q && !wr_dn_done_q;
        if (s_axi.bready && !wr_up_done_q) wr_up_done_d = 1'b1;
        if (m_axi.bvalid && m_axi.bready)  wr_dn_done_d = 1'b1;
        if (wr_up_done_d && wr_dn_done_d)  wr_state_d   = WrIdle;
      end
      default: wr_state_d = WrIdle;
    endcase
    if (wr_tmo) begin
      wr_state_d   = WrTmo;
      bresp_d      = RespSlverr;
      wr_up_done_d = 1'b0;
      wr_dn_done_d = 1'b0;
    end
  end

  always_comb begin
    rd_state_d   = rd_state_q;
    araddr_d     = araddr_q;
    arprot_d     = arprot_q;
    ar_pend_d    = ar_pend_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rd_up_done_d = rd_up_done_q;
    rd_dn_done_d = rd_dn_done_q;
    rd_timer_d   = rd_timer_q;
    rd_tmo       = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    m_axi.rready  = 1'b0;
    if (ar_pend_q && m_axi.arready) ar_pend_d = 1'b0;
    unique case (rd_state_q)
      RdIdle: begin
        s_axi.arready = 1'b1;
        if (s_axi.arvalid) begin
          araddr_d   = s_axi.araddr;
          arprot_d   = s_axi.arprot;
          ar_pend_d  = 1'b1;
          rd_timer_d = '0;
          rd_state_d = RdReq;
        end
      end
      RdReq: begin
        rd_timer_d = rd_timer_q + CNT_WIDTH'(1);
        if (rd_timer_q == TmoLast) rd_tmo     = 1'b1;
        else if (!ar_pend_d)       rd_state_d = RdResp;
      end
      RdResp: begin
        m_axi.rready = 1'b1;
        rd_timer_d   = rd_timer_q + CNT_WIDTH'(1);
        if (m_axi.rvalid) begin
          rdata_d    = m_axi.rdata;
          rresp_d    = m_axi.rresp;
          rd_state_d = RdData;
        end else if (rd_timer_q == TmoLast) begin
          rd_tmo = 1'b1;
        end
      end
      RdData: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) rd_state_d = RdIdle;
      end
      RdTmo: begin
        s_axi.rvalid = !rd_up_done_q;
        m_axi.rready = !ar_pend_q && !rd_dn_done_q;
        if (s_axi.rready && !rd_up_done_q) rd_up_done_d = 1'b1;
        if (m_axi.rvalid && m_axi.rready)  rd_dn_done_d = 1'b1;
        if (rd_up_done_d && rd_dn_done_d)  rd_state_d   = RdIdle;
      end
      default: rd_state_d = RdIdle;
    endcase
    if (rd_tmo) begin
      rd_state_d   = RdTmo;
      rdata_d      = '0;
      rresp_d      = RespSlverr;
      rd_up_done_d = 1'b0;
      rd_dn_done_d = 1'b0;
    end
  end

  assign tmo_sum     = {1'b0, tmo_count_q} + 17'(wr_tmo) + 17'(rd_tmo);
  assign tmo_count_d = tmo_sum[16] ? 16'hFFFF : tmo_sum[15:0];

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_state_q <= WrIdle;       rd_state_q <= RdIdle;
      aw_got_q <= 1'b0;           w_got_q <= 1'b0;
      aw_pend_q <= 1'b0;          w_pend_q <= 1'b0;          ar_pend_q <= 1'b0;
      awaddr_q <= '0;             awprot_q <= '0;            wdata_q <= '0;
      wstrb_q <= '0;              bresp_q <= '0;
      araddr_q <= '0;             arprot_q <= '0;            rdata_q <= '0;
      rresp_q <= '0;
      wr_up_done_q <= 1'b0;       wr_dn_done_q <= 1'b0;
      rd_up_done_q <= 1'b0;       rd_dn_done_q <= 1'b0;
      wr_timer_q <= '0;           rd_timer_q <= '0;
      wr_tmo_pulse_q <= 1'b0;     rd_tmo_pulse_q <= 1'b0;
      tmo_count_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;   rd_state_q <= rd_state_d;
      aw_got_q <= aw_got_d;       w_got_q <= w_got_d;
      aw_pend_q <= aw_pend_d;     w_pend_q <= w_pend_d;      ar_pend_q <= ar_pend_d;
      awaddr_q <= awaddr_d;       awprot_q <= awprot_d;      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;         bresp_q <= bresp_d;
      araddr_q <= araddr_d;       arprot_q <= arprot_d;      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      wr_up_done_q <= wr_up_done_d; wr_dn_done_q <= wr_dn_done_d;
      rd_up_done_q <= rd_up_done_d; rd_dn_done_q <= rd_dn_done_d;
      wr_timer_q <= wr_timer_d;   rd_timer_q <= rd_timer_d;
      wr_tmo_pulse_q <= wr_tmo;   rd_tmo_pulse_q <= rd_tmo;
      tmo_count_q <= tmo_count_d;
    end
  end

`ifdef AXIL_USR_TMO_ADDR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] tmo_addr_q;
  // Write address wins when both paths time out together.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset)  tmo_addr_q <= '0;
    else if (wr_tmo) tmo_addr_q <= awaddr_q;
    else if (rd_tmo) tmo_addr_q <= araddr_q;
  end
  assign tmo_addr = tmo_addr_q;
`else
  assign tmo_addr = '0;
`endif

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = awprot_q;
  assign m_axi.awvalid = aw_pend_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = w_pend_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = arprot_q;
  assign m_axi.arvalid = ar_pend_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign wr_tmo_pulse  = wr_tmo_pulse_q;
  assign rd_tmo_pulse  = rd_tmo_pulse_q;
  assign tmo_count     = tmo_count_q;
endmodule

// File: tb/tb_axil_usr_timeout_guard.sv
// Scoreboard bench for axil_usr_timeout_guard with TIMEOUT_CYCLES=16 and a delay-programmable
// downstream responder; expected responses are queued at issue and checked by monitors.
module tb_axil_usr_timeout_guard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_usr_timeout_guard_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) s_if ();
  axil_usr_timeout_guard_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m_if ();
  logic        wr_p, rd_p;
  logic [15:0] tmo_count;
  logic [63:0] tmo_addr;

  axil_usr_timeout_guard #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(16)
  ) dut (
    .axi_aclk(clk), .axi_areset(rst), .s_axi(s_if), .m_axi(m_if),
    .wr_tmo_pulse(wr_p), .rd_tmo_pulse(rd_p), .tmo_count(tmo_count), .tmo_addr(tmo_addr)
  );

`ifdef AXIL_USR_TMO_ADDR_CAPTURE_EN
  localparam logic [63:0] ExpBothAddr = 64'h5000;
`else
  localparam logic [63:0] ExpBothAddr = 64'h0;
`endif

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [66:0] exp_maw[$];
  logic [71:0] exp_mw[$];
  logic [66:0] exp_mar[$];
  logic [1:0]  exp_b[$];
  logic [65:0] exp_r[$];
  int b_delay = 3, r_delay = 3;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [63:0] r_data_cfg = '0;
  int wr_req_cyc = 0, wr_pulse_cyc = 0, dn_b_cyc = 0;
  int wr_pulse_cnt = 0, rd_pulse_cnt = 0, both_pulse_cnt = 0, up_b_cnt = 0;
  logic awv_prev = 1'b0, aw_seen, w_seen, ar_seen;
  int bn, rn, k, late;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [11:0] ctrl_vec();
    return {s_if.awready, s_if.wready, s_if.arready, s_if.bvalid, s_if.rvalid,
            m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready, wr_p, rd_p};
  endfunction

  function automatic logic rdy(int ch);
    return (ch == 0) ? s_if.awready : (ch == 1) ? s_if.wready : s_if.arready;
  endfunction

  task automatic push_wr(input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp);
    exp_maw.push_back({3'b010, a});
    exp_mw.push_back({8'hFF, d});
    exp_b.push_back(resp);
  endtask

  task automatic push_rd(input logic [63:0] a, input logic [1:0] resp, input logic [63:0] d);
    exp_mar.push_back({3'b001, a});
    exp_r.push_back({resp, d});
  endtask

  // ch: 0=AW, 1=W, 2=AR. Called at posedge+1; returns at posedge+1 after the handshake.
  task automatic send(input int ch, input logic [63:0] v);
    int n = 0;
    case (ch)
      0:       begin s_if.awaddr = v; s_if.awprot = 3'b010; s_if.awvalid = 1'b1; end
      1:       begin s_if.wdata = v; s_if.wstrb = 8'hFF; s_if.wvalid = 1'b1; end
      default: begin s_if.araddr = v; s_if.arprot = 3'b001; s_if.arvalid = 1'b1; end
    endcase
    @(negedge clk);
    while (!rdy(ch) && n < 200) begin @(negedge clk); n++; end
    chk("upstream_handshake", rdy(ch), 1'b1);
    @(posedge clk); #1;
    case (ch)
      0:       s_if.awvalid = 1'b0;
      1:       s_if.wvalid = 1'b0;
      default: s_if.arvalid = 1'b0;
    endcase
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b.size() + exp_r.size() + exp_maw.size() + exp_mw.size() + exp_mar.size()) != 0
           && n < 300) begin
      @(posedge clk); n++;
    end
    chk("drain_queues_empty",
        exp_b.size() + exp_r.size() + exp_maw.size() + exp_mw.size() + exp_mar.size(), 0);
    repeat (30) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transfer on either side.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (s_if.bvalid && s_if.bready) begin
        up_b_cnt++;
        chk("s_b_expected", exp_b.size() > 0, 1'b1);
        if (exp_b.size() > 0) chk("s_bresp", s_if.bresp, exp_b.pop_front());
      end
      if (s_if.rvalid && s_if.rready) begin
        chk("s_r_expected", exp_r.size() > 0, 1'b1);
        if (exp_r.size() > 0) chk("s_r", {s_if.rresp, s_if.rdata}, exp_r.pop_front());
      end
      if (m_if.awvalid && m_if.awready) begin
        chk("m_aw_expected", exp_maw.size() > 0, 1'b1);
        if (exp_maw.size() > 0) chk("m_aw", {m_if.awprot, m_if.awaddr}, exp_maw.pop_front());
      end
      if (m_if.wvalid && m_if.wready) begin
        chk("m_w_expected", exp_mw.size() > 0, 1'b1);
        if (exp_mw.size() > 0) chk("m_w", {m_if.wstrb, m_if.wdata}, exp_mw.pop_front());
      end
      if (m_if.arvalid && m_if.arready) begin
        chk("m_ar_expected", exp_mar.size() > 0, 1'b1);
        if (exp_mar.size() > 0) chk("m_ar", {m_if.arprot, m_if.araddr}, exp_mar.pop_front());
      end
      if (m_if.awvalid && !awv_prev) wr_req_cyc = cyc;
      if (m_if.bvalid && m_if.bready) dn_b_cyc = cyc;
      if (wr_p) begin wr_pulse_cnt++; wr_pulse_cyc = cyc; end
      if (rd_p) rd_pulse_cnt++;
      if (wr_p && rd_p) both_pulse_cnt++;
    end
    awv_prev = m_if.awvalid;
  end

  // Downstream DUT model: B after b_delay cycles once AW and W are both accepted; <0 = never.
  initial forever begin
    aw_seen = 1'b0;
    w_seen  = 1'b0;
    while (!(aw_seen && w_seen)) begin
      @(negedge clk);
      if (rst) begin aw_seen = 1'b0; w_seen = 1'b0; end
      else begin
        if (m_if.awvalid && m_if.awready) aw_seen = 1'b1;
        if (m_if.wvalid && m_if.wready)   w_seen  = 1'b1;
      end
    end
    if (b_delay >= 0) begin
      repeat (b_delay) @(posedge clk);
      #1 m_if.bvalid = 1'b1;
      m_if.bresp = b_resp_cfg;
      bn = 0;
      do begin @(negedge clk); bn++; end while (!m_if.bready && bn < 200);
      @(posedge clk); #1 m_if.bvalid = 1'b0;
    end
  end

  initial forever begin
    ar_seen = 1'b0;
    while (!ar_seen) begin
      @(negedge clk);
      if (!rst && m_if.arvalid && m_if.arready) ar_seen = 1'b1;
    end
    if (r_delay >= 0) begin
      repeat (r_delay) @(posedge clk);
      #1 m_if.rvalid = 1'b1;
      m_if.rdata = r_data_cfg;
      m_if.rresp = r_resp_cfg;
      rn = 0;
      do begin @(negedge clk); rn++; end while (!m_if.rready && rn < 200);
      @(posedge clk); #1 m_if.rvalid = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = 1'b0; s_if.bready = 1'b1;
    s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = 1'b0; s_if.rready = 1'b1;
    m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
    m_if.bvalid = 1'b0; m_if.bresp = '0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", ctrl_vec(), 12'b1110_0000_0000);
    chk("reset_cnt_addr", {tmo_count, tmo_addr}, 80'h0);
    @(posedge clk); #1;

    // Normal write, B after 3 cycles.
    b_delay = 3; b_resp_cfg = 2'b00;
    push_wr(64'h1000, 64'hA5A5, 2'b00);
    fork send(0, 64'h1000); send(1, 64'hA5A5); join
    drain();
    chk("t1_no_wr_tmo", wr_pulse_cnt, 0);

    // W two cycles ahead of AW.
    push_wr(64'h1100, 64'h5A5A_0001, 2'b00);
    s_if.wdata = 64'h5A5A_0001; s_if.wstrb = 8'hFF; s_if.wvalid = 1'b1;
    @(negedge clk);
    chk("t2_ready_before_w", {s_if.awready, s_if.wready}, 2'b11);
    @(posedge clk); #1 s_if.wvalid = 1'b0;
    @(negedge clk);
    chk("t2_only_wready_dropped", {s_if.awready, s_if.wready}, 2'b10);
    @(posedge clk); #1;
    send(0, 64'h1100);
    drain();

    // Write timeout; late DUT B at cycle 40 discarded; next AW held off until then.
    b_delay = 40; b_resp_cfg = 2'b01;
    push_wr(64'h2000, 64'h1234, 2'b10);
    fork send(0, 64'h2000); send(1, 64'h1234); join
    @(negedge clk);
    k = wr_req_cyc;
    push_wr(64'h3000, 64'h5678, 2'b00);
    fork send(0, 64'h3000); send(1, 64'h5678); join_none
    while (cyc < k + 30) @(negedge clk);
    b_delay = 2;
    chk("t3_pulse_offset", wr_pulse_cyc - k, 16);
    chk("t3_tmo_count", tmo_count, 16'd1);
    chk("t3_aw_blocked", {s_if.awvalid, s_if.awready}, 2'b10);
    while (cyc < k + 41) @(negedge clk);
    chk("t3_late_dn_b", dn_b_cyc - k, 40);
    late = dn_b_cyc;
    @(posedge clk); #1 b_resp_cfg = 2'b00;
    drain();
    chk("t3_next_aw_after_late_b", wr_req_cyc > late, 1'b1);
    chk("t3_single_pulse", wr_pulse_cnt, 1);
    chk("t3_upstream_b_count", up_b_cnt, 4);

    // Read data on the timer's last cycle wins; one cycle later times out.
    r_delay = 15; r_resp_cfg = 2'b00; r_data_cfg = 64'hDEAD_BEEF_0123_4567;
    push_rd(64'h4000, 2'b00, 64'hDEAD_BEEF_0123_4567);
    send(2, 64'h4000);
    drain();
    chk("t4_no_rd_tmo", rd_pulse_cnt, 0);
    r_delay = 16;
    push_rd(64'h8000, 2'b10, 64'h0);
    send(2, 64'h8000);
    drain();
    chk("t4b_rd_tmo", rd_pulse_cnt, 1);
    chk("t4b_tmo_count", tmo_count, 16'd2);

    // Simultaneous write and read timeout.
    b_delay = 20; r_delay = 20;
    push_wr(64'h5000, 64'hCAFE, 2'b10);
    push_rd(64'h6000, 2'b10, 64'h0);
    fork send(0, 64'h5000); send(1, 64'hCAFE); send(2, 64'h6000); join
    drain();
    chk("t5_both_pulse", both_pulse_cnt, 1);
    chk("t5_tmo_count", tmo_count, 16'd4);
    chk("t5_tmo_addr", tmo_addr, ExpBothAddr);

    // Reset while waiting in the read response state.
    r_delay = -1;
    exp_mar.push_back({3'b001, 64'h7000});
    send(2, 64'h7000);
    repeat (3) @(negedge clk);
    chk("t6_in_rd_resp", {m_if.rready, s_if.arready}, 2'b10);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_reset_ctrl", ctrl_vec(), 12'b1110_0000_0000);
    chk("t6_reset_cnt", tmo_count, 16'd0);
    chk("t6_queues_empty", exp_b.size() + exp_r.size() + exp_mar.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_usr_timeout_guard.md
Name: axil_usr_timeout_guard

Overview:
- AXI4-Lite stage placed directly downstream of the bridge's user master port (m_axi_usr_*), between the bridge and the user DUT.
- Forwards one write and one read at a time. Read and write paths are independent and may both be outstanding at once.
- Each path has a timer. If the DUT does not complete within TIMEOUT_CYCLES, the block returns SLVERR upstream so the bridge's descriptor completes. The late DUT transaction is still completed downstream and its response is discarded, so the DUT-side protocol stays legal.

Parameters:
- ADDR_WIDTH, 64, AXI address width (32 or 64).
- DATA_WIDTH, 64, AXI data width (32 or 64).
- TIMEOUT_CYCLES, 1024, cycles allowed from forwarding start to DUT response. Minimum 2.
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES)+1, timer width. Localparam, not overridable.

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  synchronous, active-high reset.
- s_axi_aw{addr,prot,valid,ready}, s_axi_w{data,strb,valid,ready}, s_axi_b{resp,valid,ready}: upstream slave write channels, fed from the bridge's m_axi_usr_*. Widths: ADDR_WIDTH, 3, DATA_WIDTH, DATA_WIDTH/8, 2, and 1 for handshake signals.
- s_axi_ar{addr,prot,valid,ready}, s_axi_r{data,resp,valid,ready}: upstream slave read channels, same widths.
- m_axi_aw*/w*/b*/ar*/r*: the identical signal set, mirrored, on the downstream master side to the DUT.
- wr_tmo_pulse  out  1  one-cycle pulse when a write times out.
- rd_tmo_pulse  out  1  one-cycle pulse when a read times out.
- tmo_count  out  16  saturating count of all timeouts.
- tmo_addr  out  ADDR_WIDTH  address of the most recent timed-out transaction (see Optional Feature).

Behaviour:
- Reset values:
  - All valids 0 and tmo pulses 0.
  - tmo_count 0, tmo_addr 0.
  - s_axi_awready, s_axi_wready and s_axi_arready are 1 because both FSMs reset to IDLE.
  - Data, response and address outputs 0.
- Write FSM states: WR_IDLE, WR_REQ, WR_RESP, WR_BRESP, WR_TMO.
  - WR_IDLE: awready and wready are 1 independently. Each accepted channel is captured and that channel's ready drops. Once both are captured, in either order or in the same cycle, go to WR_REQ and clear the timer to 0.
  - WR_REQ: m_axi_awvalid and m_axi_wvalid hold with the captured payload until each handshakes. Valids are never dropped early. When both have handshaked, go to WR_RESP.
  - WR_RESP: m_axi_bready is 1. On the B handshake, capture bresp and go to WR_BRESP.
  - WR_BRESP: s_axi_bvalid is 1 with the captured bresp. On s_axi_bready, go to WR_IDLE.
  - Timer: increments every cycle in WR_REQ and WR_RESP.
  - Timeout: if the timer equals TIMEOUT_CYCLES-1 in a cycle with no m_axi_b handshake, go to WR_TMO and pulse wr_tmo_pulse. A B handshake in that same cycle wins, and no timeout occurs.
  - WR_TMO:
    - s_axi_bvalid is 1 with bresp=2'b10 (SLVERR) until s_axi_bready.
    - In parallel, outstanding downstream aw/w valids keep being driven until accepted, then m_axi_bready is 1.
    - The late DUT B response is discarded.
    - Exit to WR_IDLE only when both the upstream B has been accepted and the downstream B has been received. Upstream stays blocked until then.
- Read FSM states: RD_IDLE, RD_REQ, RD_RESP, RD_DATA, RD_TMO.
  - Same structure as the write FSM.
  - On timeout, s_axi_rdata is 0 and rresp is 2'b10.
  - Late m_axi_r data is discarded.
- Latency: one cycle of registering per direction, in both directions. s_axi_bvalid rises no earlier than 1 cycle after the m_axi_b handshake.
- m_axi_*prot, addr, data and strb are passed unchanged from the captured values.
- tmo_count increments by 1 per timeout event and saturates at 16'hFFFF. If a write and a read time out in the same cycle, it increments by 2, clamped at saturation.
- Reset asserted mid-transaction forces both FSMs to IDLE immediately. No draining is performed; the system resets the DUT together with this block.

Optional Feature:
- Macro: AXIL_USR_TMO_ADDR_CAPTURE_EN.
- Defined: on each timeout, tmo_addr loads the captured awaddr or araddr. If both time out in the same cycle, the write address wins.
- Undefined: tmo_addr is tied to 0 and no capture registers are built.

Test Plan:
- TIMEOUT_CYCLES=16; write addr 0x1000, data 0xA5A5; DUT accepts AW/W in 1 cycle and returns bresp 2'b00 after 3 cycles -> s_axi_bresp=2'b00, no wr_tmo_pulse, m_axi_wdata=0xA5A5.
- W arrives 2 cycles before AW -> single downstream write with the correct addr and data; s_axi_awready and s_axi_wready each drop after their own capture.
- DUT never asserts bvalid -> wr_tmo_pulse exactly 16 cycles after entering WR_REQ, s_axi_bresp=2'b10, tmo_count=1. Next AW stays blocked (awready=0) until DUT B arrives; DUT B arriving at cycle 40 is discarded with no upstream B; FSM returns to IDLE.
- DUT rvalid on the exact cycle the timer equals 15 -> normal response with the DUT rdata, no timeout.
- Write and read both time out in the same cycle -> both pulses high, tmo_count += 2, tmo_addr = write address with the macro defined, 0 without.
- Assert axi_areset while in RD_RESP -> next cycle all valids 0, arready=1, tmo_count=0.
